instr_sequencer: RTL

- Parametrised fetch/decode sequencer for the mnpk01 core.
- Fetches an opcode byte from program ROM, then collects its operand bytes (count set by a fixed opcode table).
- Issues the assembled instruction to the execute stage over a valid/ready handshake.
- Owns the program counter and accepts redirect (jump/branch) requests from execute.

---
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Fetch/decode sequencer for the mnpk01 core: fetches opcode + operands from a combinational ROM,
// issues over valid/ready, owns the PC. Optional trap on illegal opcodes via ILLEGAL_TRAP_EN.
//
// state     | meaning
// S_FETCH   | read opcode at pc, decode operand count
// S_OPERAND | collect one operand word per cycle into slot idx
// S_ISSUE   | instruction presented to execute, wait for ready
// S_HALT    | HLT retired; frozen until reset
module instr_sequencer #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 16,
  parameter int                 MAX_OPS  = 3,
  parameter logic [ADDR_W-1:0]  TRAP_VEC = 16'h0010
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  input  logic                        pc_load,
  input  logic [ADDR_W-1:0]           pc_load_addr,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [DATA_W-1:0]           instr_opcode,
  output logic [MAX_OPS*DATA_W-1:0]   instr_ops,
  output logic [1:0]                  instr_nops,
  output logic                        halted,
  output logic                        illegal
);

  localparam int IDX_W = $clog2(MAX_OPS);

  localparam logic [DATA_W-1:0] OP_NOP = DATA_W'(8'h00);
  localparam logic [DATA_W-1:0] OP_LDI = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_MOV = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] OP_LDW = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] OP_HLT = DATA_W'(8'hFF);

  typedef enum logic [1:0] {S_FETCH, S_OPERAND, S_ISSUE, S_HALT} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           pc_q, pc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_W-1:0]           opcode_q, opcode_d;
  logic [MAX_OPS*DATA_W-1:0]   ops_q, ops_d;
  logic [1:0]                  nops_q, nops_d;

  // Unknown opcodes decode to zero operands, so without the trap they issue like a NOP.
  function automatic logic [1:0] op_count(input logic [DATA_W-1:0] op);
    case (op)
      OP_LDI, OP_MOV: op_count = 2'd2;
      OP_LDW:         op_count = 2'd3;
      default:        op_count = 2'd0;
    endcase
  endfunction

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  function automatic logic op_legal(input logic [DATA_W-1:0] op);
    op_legal = (op == OP_NOP) || (op == OP_LDI) || (op == OP_MOV) ||
               (op == OP_LDW) || (op == OP_HLT);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    ops_d    = ops_q;
    nops_d   = nops_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
`ifdef ILLEGAL_TRAP_EN
        if (!op_legal(rom_data)) begin
          pc_d      = TRAP_VEC;
          illegal_d = 1'b1;
        end else
`endif
        begin
          opcode_d = rom_data;
          ops_d    = '0;
          nops_d   = op_count(rom_data);
          pc_d     = pc_q + 1'b1;
          if (op_count(rom_data) == 2'd0) begin
            state_d = S_ISSUE;
          end else begin
            idx_d   = '0;
            state_d = S_OPERAND;
          end
        end
      end
      S_OPERAND: begin
        ops_d[idx_q*DATA_W +: DATA_W] = rom_data;
        pc_d = pc_q + 1'b1;
        if (idx_q == IDX_W'(nops_q - 2'd1)) state_d = S_ISSUE;
        else                                idx_d   = idx_q + 1'b1;
      end
      S_ISSUE: begin
        if (instr_ready) state_d = (opcode_q == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // Redirect wins over everything except HALT; a handshake in the same cycle still completes.
    if (pc_load && state_q != S_HALT) begin
      pc_d    = pc_load_addr;
      state_d = S_FETCH;
      idx_d   = '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      idx_q    <= '0;
      opcode_q <= '0;
      ops_q    <= '0;
      nops_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      ops_q    <= ops_d;
      nops_q   <= nops_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign rom_addr     = pc_q;
  assign instr_valid  = (state_q == S_ISSUE);
  assign halted       = (state_q == S_HALT);
  assign instr_opcode = opcode_q;
  assign instr_ops    = ops_q;
  assign instr_nops   = nops_q;

endmodule
